// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART receive controller
package uart_pkg;

    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLKDIV = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_RX_BUSY   = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_RX_EN       = 0;
    localparam int CTRL_IRQ_DATA_EN = 1;
    localparam int CTRL_IRQ_ERR_EN  = 2;
    localparam int CTRL_THR_LSB     = 4;

    // bit 3 of CTRL is unimplemented and always reads back as zero
    localparam logic [7:0] CTRL_WMASK = 8'hF7;

    localparam logic [31:0] CLKDIV_RST_DEFAULT = 32'd434;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - register bus between the user project and the receive controller
interface uart_rx_ctrl_if;
    logic [1:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_addr, bus_we, bus_re, bus_wdata, input bus_rdata);
    modport slave  (input bus_addr, bus_we, bus_re, bus_wdata, output bus_rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO that accepts a push while full when a pop happens in the same cycle
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // when full, wr_ptr == rd_ptr: the head is read out before its slot is reused
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receiver handshake, divisor ownership, byte buffering, status and interrupt
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          AW         = 3,
    parameter logic [31:0] CLKDIV_RST = CLKDIV_RST_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_rq,
    input  logic [7:0]           rx_data,
    input  logic                 rx_frame_err,
    input  logic                 rx_busy,
    output logic                 rx_finish,
    output logic [31:0]          clk_div,
    uart_rx_ctrl_if.slave        bus,
    output logic                 irq
);

    rx_state_t   state;
    logic [7:0]  rx_byte;
    logic [7:0]  ctrl;
    logic        overrun;
    logic        frame_err;
    logic        pend_valid;
    logic [31:0] pend_div;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count;

    logic        wr_status;
    logic        wr_clkdiv;
    logic        wr_ctrl;
    logic        overrun_set;
    logic [4:0]  count5;
    logic [3:0]  thr;
    logic [31:0] status_word;

    always_comb begin
        wr_status   = bus.bus_we && (bus.bus_addr == ADDR_STATUS);
        wr_clkdiv   = bus.bus_we && (bus.bus_addr == ADDR_CLKDIV);
        wr_ctrl     = bus.bus_we && (bus.bus_addr == ADDR_CTRL);
        fifo_pop    = bus.bus_re && (bus.bus_addr == ADDR_RXDATA);
        fifo_push   = (state == ACK) && ctrl[CTRL_RX_EN];
        overrun_set = fifo_push && fifo_full && !fifo_pop;
        count5      = 5'(fifo_count);
        thr         = (ctrl[CTRL_THR_LSB +: 4] == 4'd0) ? 4'd1 : ctrl[CTRL_THR_LSB +: 4];
        status_word = '0;
        status_word[ST_NOT_EMPTY]      = !fifo_empty;
        status_word[ST_FULL]           = fifo_full;
        status_word[ST_OVERRUN]        = overrun;
        status_word[ST_FRAME_ERR]      = frame_err;
        status_word[ST_RX_BUSY]        = rx_busy;
        status_word[ST_COUNT_LSB +: 5] = count5;
    end

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (rx_byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_byte   <= '0;
            rx_finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_finish <= rx_rq;
                    if (rx_rq) begin
                        rx_byte <= rx_data;
                        state   <= ACK;
                    end
                end
                default: begin
                    rx_finish <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl          <= '0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
            pend_valid    <= 1'b0;
            pend_div      <= '0;
            clk_div       <= CLKDIV_RST;
            bus.bus_rdata <= '0;
            irq           <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus.bus_wdata[7:0] & CTRL_WMASK;

            // hardware set wins over a same-cycle write-one-to-clear
            overrun   <= overrun_set  || (overrun   && !(wr_status && bus.bus_wdata[ST_OVERRUN]));
            frame_err <= rx_frame_err || (frame_err && !(wr_status && bus.bus_wdata[ST_FRAME_ERR]));

            // the divisor never changes under a frame in flight
            if (wr_clkdiv) begin
                if (rx_busy) begin
                    pend_valid <= 1'b1;
                    pend_div   <= bus.bus_wdata;
                end else begin
                    pend_valid <= 1'b0;
                    clk_div    <= bus.bus_wdata;
                end
            end else if (pend_valid && !rx_busy) begin
                pend_valid <= 1'b0;
                clk_div    <= pend_div;
            end

            if (bus.bus_re) begin
                case (bus.bus_addr)
                    ADDR_RXDATA: bus.bus_rdata <= fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                    ADDR_STATUS: bus.bus_rdata <= status_word;
                    ADDR_CLKDIV: bus.bus_rdata <= pend_valid ? pend_div : clk_div;
                    default:     bus.bus_rdata <= {24'd0, ctrl};
                endcase
            end

            irq <= (ctrl[CTRL_IRQ_DATA_EN] && (count5 >= {1'b0, thr}))
                || (ctrl[CTRL_IRQ_ERR_EN] && (overrun || frame_err));
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for the UART receive controller
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rx_rq;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        rx_busy;
    logic        rx_finish;
    logic [31:0] clk_div;
    logic        irq;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_rq        (rx_rq),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .rx_finish    (rx_finish),
        .clk_div      (clk_div),
        .bus          (bus.slave),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];
    logic [7:0] m_ctrl;
    logic       m_ov;
    logic       m_fe;
    logic       m_busy;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int          c;
        c = sb.size();
        s = '0;
        s[0]    = (c != 0);
        s[1]    = (c == 8);
        s[2]    = m_ov;
        s[3]    = m_fe;
        s[4]    = m_busy;
        s[12:8] = 5'(c);
        return s;
    endfunction

    // every task starts and ends one time unit after a rising edge
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_we    = 1'b1;
        @(posedge clk); #1;
        bus.bus_we    = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus.bus_addr = a;
        bus.bus_re   = 1'b1;
        @(posedge clk); #1;
        bus.bus_re   = 1'b0;
        d = bus.bus_rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_rq   = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_rq   = 1'b0;
        check("rx_finish_ack", {31'd0, rx_finish}, 32'd1);
        if (m_ctrl[0]) begin
            if (sb.size() < 8) sb.push_back(b);
            else m_ov = 1'b1;
        end
        @(posedge clk); #1;
        check("rx_finish_drop", {31'd0, rx_finish}, 32'd0);
    endtask

    task automatic read_byte();
        logic [31:0] e;
        bus_rd(ADDR_RXDATA, rd);
        e = (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'd0;
        check("rxdata", rd, e);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] e;
        e = exp_status();
        bus_rd(ADDR_STATUS, rd);
        check(tag, rd, e);
    endtask

    initial begin
        rst_n = 1'b0; rx_rq = 1'b0; rx_data = '0; rx_frame_err = 1'b0; rx_busy = 1'b0;
        bus.bus_addr = '0; bus.bus_we = 1'b0; bus.bus_re = 1'b0; bus.bus_wdata = '0;
        m_ctrl = '0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst_clk_div", clk_div, 32'd434);
        check("rst_rx_finish", {31'd0, rx_finish}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_rd(ADDR_CLKDIV, rd);
        check("rst_clkdiv_reg", rd, 32'd434);
        read_status("rst_status");
        bus_rd(ADDR_CTRL, rd);
        check("rst_ctrl", rd, 32'd0);

        bus_wr(ADDR_CTRL, 32'h13); m_ctrl = 8'h13;
        send_byte(8'hA5);
        read_status("status_one");
        check("irq_data", {31'd0, irq}, 32'd1);
        read_byte();
        read_status("status_drained");
        check("irq_cleared", {31'd0, irq}, 32'd0);

        bus_wr(ADDR_CTRL, 32'h12); m_ctrl = 8'h12;
        send_byte(8'h55);
        read_status("status_rx_disabled");
        bus_wr(ADDR_CTRL, 32'h13); m_ctrl = 8'h13;

        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        read_status("status_overrun");
        for (int i = 0; i < 9; i++) read_byte();
        bus_wr(ADDR_STATUS, 32'h4); m_ov = 1'b0;
        read_status("status_ov_cleared");

        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        rx_rq   = 1'b1;
        rx_data = 8'h18;
        @(posedge clk); #1;
        rx_rq = 1'b0;
        check("rx_finish_full", {31'd0, rx_finish}, 32'd1);
        bus.bus_addr = ADDR_RXDATA;
        bus.bus_re   = 1'b1;
        @(posedge clk); #1;
        bus.bus_re = 1'b0;
        check("pop_with_push", bus.bus_rdata, {24'd0, sb.pop_front()});
        sb.push_back(8'h18);
        read_status("status_full_no_ov");
        for (int i = 0; i < 8; i++) read_byte();

        bus_wr(ADDR_CTRL, 32'h17); m_ctrl = 8'h17;
        rx_frame_err = 1'b1;
        @(posedge clk); #1;
        rx_frame_err = 1'b0; m_fe = 1'b1;
        read_status("status_frame_err");
        check("irq_err", {31'd0, irq}, 32'd1);
        rx_frame_err = 1'b1;
        bus_wr(ADDR_STATUS, 32'h8);
        rx_frame_err = 1'b0;
        read_status("fe_set_wins");
        bus_wr(ADDR_STATUS, 32'h8); m_fe = 1'b0;
        read_status("fe_cleared");
        idle(2);
        check("irq_err_cleared", {31'd0, irq}, 32'd0);

        rx_busy = 1'b1; m_busy = 1'b1;
        read_status("status_busy");
        bus_wr(ADDR_CLKDIV, 32'h99);
        bus_wr(ADDR_CLKDIV, 32'h56);
        check("clk_div_held", clk_div, 32'd434);
        bus_rd(ADDR_CLKDIV, rd);
        check("clkdiv_pending", rd, 32'h56);
        rx_busy = 1'b0; m_busy = 1'b0;
        @(posedge clk); #1;
        check("clk_div_applied", clk_div, 32'h56);
        bus_wr(ADDR_CLKDIV, 32'h1B2);
        check("clk_div_direct", clk_div, 32'h1B2);
        bus_rd(ADDR_CLKDIV, rd);
        check("clkdiv_readback", rd, 32'h1B2);

        bus_wr(ADDR_CTRL, 32'h13); m_ctrl = 8'h13;
        send_byte(8'hC1);
        send_byte(8'hC2);
        read_status("status_pre_reset");
        check("irq_pre_reset", {31'd0, irq}, 32'd1);
        rx_busy = 1'b1;
        bus_wr(ADDR_CLKDIV, 32'h77);
        rx_rq   = 1'b1;
        rx_data = 8'hC3;
        @(posedge clk); #2;
        check("rx_finish_pre_reset", {31'd0, rx_finish}, 32'd1);
        rst_n = 1'b0;
        #1;
        rx_rq = 1'b0;
        check("mid_rst_clk_div", clk_div, 32'd434);
        check("mid_rst_rx_finish", {31'd0, rx_finish}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_rdata", bus.bus_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rx_busy = 1'b0;
        sb.delete(); m_ctrl = '0; m_ov = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
        idle(2);
        check("post_rst_clk_div", clk_div, 32'd434);
        read_status("post_rst_status");
        bus_rd(ADDR_CTRL, rd);
        check("post_rst_ctrl", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
